// File: rtl/hex_result_display.sv
// Three-digit multiplexed hex display for the 9-bit adder result (carry, high nibble, low nibble).
// Results are staged in a pending register and committed only at frame boundaries.
module hex_result_display #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter bit BLANK_LZ     = 1'b1
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic [8:0] R,
    input  logic       Load,
    input  logic       Enable,
    output logic [6:0] Seg,
    output logic [2:0] An,
    output logic       Ovf,
    output logic       Loaded
);

    localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic [2:0] {BLANK0, SHOW0, BLANK1, SHOW1, BLANK2, SHOW2} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [8:0]    disp, pend_val;
    logic          pend;
    logic          is_show, last, boundary;
    logic [6:0]    seg_n;
    logic [2:0]    an_n;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        is_show  = (state == SHOW0) || (state == SHOW1) || (state == SHOW2);
        last     = (cnt == (is_show ? SHOW_LAST : BLANK_LAST));
        boundary = !Enable || ((state == SHOW2) && last);
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        if (!Enable) begin
            state_n = BLANK0;
            cnt_n   = '0;
        end else if (last) begin
            cnt_n = '0;
            case (state)
                BLANK0:  state_n = SHOW0;
                SHOW0:   state_n = BLANK1;
                BLANK1:  state_n = SHOW1;
                SHOW1:   state_n = BLANK2;
                BLANK2:  state_n = SHOW2;
                default: state_n = BLANK0;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    // disp is stable here: it only changes on edges that enter BLANK0.
    always_comb begin
        seg_n = 7'h7F;
        an_n  = 3'b111;
        case (state_n)
            SHOW0: begin
                seg_n = seg7(disp[3:0]);
                an_n  = 3'b110;
            end
            SHOW1: begin
                seg_n = seg7(disp[7:4]);
                if (!(BLANK_LZ && (disp[8:4] == 5'd0))) an_n = 3'b101;
            end
            SHOW2: begin
                seg_n = seg7({3'b000, disp[8]});
                if (!(BLANK_LZ && !disp[8])) an_n = 3'b011;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state    <= BLANK0;
            cnt      <= '0;
            Seg      <= 7'h7F;
            An       <= 3'b111;
            Ovf      <= 1'b0;
            Loaded   <= 1'b0;
            disp     <= '0;
            pend_val <= '0;
            pend     <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            Seg    <= seg_n;
            An     <= an_n;
            Loaded <= 1'b0;
            if (boundary) begin
                // A load landing on the boundary bypasses pending and wins over it.
                if (Load) begin
                    disp   <= R;
                    Ovf    <= R[8];
                    Loaded <= 1'b1;
                end else if (pend) begin
                    disp   <= pend_val;
                    Ovf    <= pend_val[8];
                    Loaded <= 1'b1;
                end
                pend <= 1'b0;
            end else if (Load) begin
                pend_val <= R;
                pend     <= 1'b1;
            end
        end
    end

endmodule

// File: doc/hex_result_display.md
Name: hex_result_display

Overview:
Downstream consumer of the 9-bit adder result: captures R on a load strobe and drives a 3-digit, time-multiplexed, common-anode seven-segment display. Digit 2 shows the carry (0/1), digit 1 shows R[7:4] and digit 0 shows R[3:0], all in hex. New results are applied only at a frame boundary, so a digit never shows a mix of old and new data. A blanking gap between digits prevents ghosting.

Parameters:
REFRESH_DIV, 50000, clock cycles each digit is lit (SHOW phase); legal range ≥2
BLANK_CYCLES, 500, clock cycles all digits are dark between digits (BLANK phase); legal range ≥1
BLANK_LZ, 1, 1 = leading-zero blanking enabled; 0 = all three digits always shown

Ports:
Clk  in  1  system clock; all logic rising-edge
nReset  in  1  asynchronous, active-low reset
R  in  9  adder result; R[8] is the carry
Load  in  1  one-cycle strobe; R is sampled when Load=1
Enable  in  1  1 = scanning active; 0 = display dark
Seg  out  7  segments {g,f,e,d,c,b,a}, active-low
An  out  3  digit anodes, active-low; An[2] = carry digit
Ovf  out  1  carry LED; equals displayed R[8]
Loaded  out  1  one-cycle pulse when the display register takes a new value

Behaviour:
- Reset (async, nReset=0): An=3'b111, Seg=7'h7F, Ovf=0, Loaded=0, display register=0, pending register=0, Pending flag=0, state=BLANK0, counter=0. All outputs are registered.
- Scan FSM states: BLANK0 → SHOW0 → BLANK1 → SHOW1 → BLANK2 → SHOW2 → BLANK0.
  - BLANK states last BLANK_CYCLES cycles. SHOW states last REFRESH_DIV cycles.
  - Counter runs 0..N-1, then the state advances and the counter returns to 0.
  - One frame = 3*(REFRESH_DIV+BLANK_CYCLES) cycles.
- Outputs per state:
  - In BLANK states: An=3'b111, Seg=7'h7F.
  - In SHOWd: An has only bit d low, and Seg carries the encoding of digit d. Both update on the same edge the state changes.
- Seg encoding, active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Leading-zero blanking (BLANK_LZ=1):
  - Digit 2 is blank (An bit stays high) when R[8]=0.
  - Digit 1 is blank when R[8]=0 and R[7:4]=0.
  - Digit 0 is never blank.
  - A blanked digit keeps its time slot; only its anode is suppressed.
- Load capture:
  - When Load=1, R is written into the pending register and Pending is set to 1.
  - A later Load before transfer overwrites the pending value (last value wins).
- Transfer to the display register happens at the frame boundary, i.e. the cycle SHOW2 ends (SHOW2 → BLANK0). If Pending=1 at that cycle:
  - display register ← pending register, Pending ← 0, Loaded=1 on the next cycle.
- Load on the boundary cycle: R goes straight to the display register, bypassing pending. Pending ← 0 and Loaded pulses.
- Enable=0:
  - FSM is held in BLANK0 with counter=0, An=3'b111, Seg=7'h7F.
  - Every cycle counts as a frame boundary, so a pending value transfers on the next edge.
  - Ovf still follows the display register.
- Enable 0→1: scanning starts from BLANK0 with counter=0.
- Ovf = display register bit 8. It changes only on a transfer.
- Reset mid-frame discards the display and pending values and any Loaded pulse. Scanning restarts from BLANK0 after release.

Test Plan (REFRESH_DIV=4, BLANK_CYCLES=1, frame=15 cycles):
1. Reset: hold nReset=0 for 3 cycles, then release with Enable=1 and no Load → An=111, Seg=7F during BLANK. Digit 0 lights with Seg=40 (An=110) for 4 cycles. Digits 1 and 2 stay dark (leading-zero blanking). Ovf=0.
2. Load R=9'h1A3 mid-frame → no display change until the SHOW2→BLANK0 edge. Loaded pulses once. Next frame: digit 0 Seg=30, digit 1 Seg=08 (An=101), digit 2 Seg=79 (An=011), Ovf=1.
3. Two loads in one frame: Load R=9'h005, then R=9'h0FF → only 0FF is shown at the boundary (digit 0 Seg=0E, digit 1 Seg=0E, digit 2 blank). Loaded pulses exactly once.
4. Load R=9'h010 on the exact boundary cycle → the display register takes 010 immediately. Next frame: digit 0 Seg=40, digit 1 Seg=79, digit 2 blank. Pending=0.
5. Enable=0 during SHOW1 → An=111 and Seg=7F on the next edge. Load R=9'h100 → Loaded pulses the cycle after, Ovf=1. Enable=1 → scan restarts at BLANK0.
6. BLANK_LZ=0 with R=9'h000 → all three digits lit with Seg=40, each for 4 cycles, separated by 1 dark cycle. Assert nReset=0 mid-SHOW1 → all outputs return to reset values asynchronously.
